// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit and its buffer.
package fetch_pkg;

   // IDLE: no request; WAIT: request out, result kept; DROP: request out, result discarded
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   localparam logic [31:0] INSTR_BYTES = 32'd4;
   localparam logic [31:0] RESET_PC    = 32'h0;
   localparam int          ENTRY_W     = 64;   // {pc, instr}

endpackage

// File: rtl/fetch_buffer.sv
// Small instruction FIFO holding {pc, instr} entries between fetch and decode.
// Flush wins over a same-cycle push or pop.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [ENTRY_W-1:0]       push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [ENTRY_W-1:0]       head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign head    = mem[rd_ptr];

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage needs no reset: contents are only visible when not empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: drives the PC register, fetches over req/ack, buffers
// words in a FIFO for decode, and handles redirects by flushing and dropping
// any in-flight fetch.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PCResult,
   output logic [31:0] PCNext,
   output logic        PCWrite,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        if_ready
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   fetch_state_t         state, state_next;
   logic [31:0]          addr_next;
   logic                 push, pop, flush;
   logic [ENTRY_W-1:0]   head;
   logic [CW-1:0]        count;
   logic                 full, empty;
   logic                 room_after_push;

   fetch_buffer #(.DEPTH(FIFO_DEPTH)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({imem_addr, imem_rdata}),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   assign imem_req = (state != IDLE);
   assign if_valid = ~empty;
   assign if_pc    = head[63:32];
   assign if_instr = head[31:0];
   assign pop      = if_valid & if_ready;

   // in WAIT the FIFO is never full, so count+1 cannot overflow CW bits
   assign room_after_push = pop | ((count + CW'(1)) < DEPTH_C);

   // state and fetch address registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         imem_addr <= RESET_PC;
      end else begin
         state     <= state_next;
         imem_addr <= addr_next;
      end
   end

   // next state and next fetch address; address only moves when no request is pending
   always_comb begin
      state_next = state;
      addr_next  = imem_addr;
      case (state)
         IDLE: begin
            if (redirect_valid) begin
               state_next = WAIT;
               addr_next  = redirect_target;
            end else if (pop || !full) begin
               state_next = WAIT;
               addr_next  = PCResult;
            end
         end
         WAIT: begin
            if (imem_ack) begin
               if (redirect_valid) begin
                  addr_next = redirect_target;
               end else if (room_after_push) begin
                  addr_next = imem_addr + INSTR_BYTES;
               end else begin
                  state_next = IDLE;
               end
            end else if (redirect_valid) begin
               state_next = DROP;
            end
         end
         DROP: begin
            // PCResult already holds the redirect target when the stale ack lands
            if (imem_ack) begin
               state_next = WAIT;
               addr_next  = redirect_valid ? redirect_target : PCResult;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // PC register control and FIFO push/flush; redirect outranks the increment
   always_comb begin
      PCWrite = 1'b0;
      PCNext  = 32'h0;
      push    = 1'b0;
      flush   = 1'b0;
      if (!rst) begin
         if (redirect_valid) begin
            PCWrite = 1'b1;
            PCNext  = redirect_target;
            flush   = 1'b1;
         end else if (state == WAIT && imem_ack) begin
            PCWrite = 1'b1;
            PCNext  = imem_addr + INSTR_BYTES;
            push    = 1'b1;
         end
      end
   end

endmodule
